// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the dual-issue scoreboard: register count,
// saturation limit and the per-register outstanding-count types.
package issue_scoreboard_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_W    = 5;
    localparam logic [2:0]  CNT_MAX  = 3'd3;

    typedef logic [REG_W-1:0]     reg_idx_t;
    typedef logic [1:0]           cnt_t;
    typedef cnt_t [NUM_REGS-1:0]  cnt_vec_t;

    // Writebacks to an idle register must never wrap the count.
    function automatic cnt_t sat_dec(input cnt_t c, input cnt_t n);
        return (c > n) ? cnt_t'(c - n) : '0;
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Per-slot readiness: sources free of pending long writes and
// destination count with headroom for one more outstanding write.
module issue_pair_check
    import issue_scoreboard_pkg::*;
(
    input  cnt_vec_t i_eff,
    input  reg_idx_t i_src1,
    input  reg_idx_t i_src2,
    input  logic     i_use1,
    input  logic     i_use2,
    input  reg_idx_t i_dest,
    input  logic     i_long,
    input  logic     i_extra,
    output logic     o_src_ok,
    output logic     o_dest_ok
);

    logic       w_s1_ok;
    logic       w_s2_ok;
    logic [2:0] w_sum;

    assign w_s1_ok = !i_use1 || (i_src1 == '0) || (i_eff[i_src1] == '0);
    assign w_s2_ok = !i_use2 || (i_src2 == '0) || (i_eff[i_src2] == '0);
    assign o_src_ok = w_s1_ok && w_s2_ok;

    // i_extra accounts for the older slot claiming the same destination.
    assign w_sum = {1'b0, i_eff[i_dest]} + {2'b00, i_extra};
    assign o_dest_ok = !i_long || (i_dest == '0) || (w_sum < CNT_MAX);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order dual-issue scoreboard tracking outstanding long-latency
// writes per architectural register, with same-cycle WB bypass.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     flush,
    input  logic     ro_stall,
    input  logic     id_a_valid,
    input  reg_idx_t id_a_src1,
    input  reg_idx_t id_a_src2,
    input  logic     id_a_use_src1,
    input  logic     id_a_use_src2,
    input  reg_idx_t id_a_dest,
    input  logic     id_a_long,
    input  logic     id_a_is_mem,
    input  logic     id_a_is_spec_op,
    input  logic     id_b_valid,
    input  reg_idx_t id_b_src1,
    input  reg_idx_t id_b_src2,
    input  logic     id_b_use_src1,
    input  logic     id_b_use_src2,
    input  reg_idx_t id_b_dest,
    input  logic     id_b_long,
    input  logic     id_b_is_mem,
    input  logic     id_b_is_spec_op,
    input  logic     wb_a_long_done,
    input  reg_idx_t wb_a_dest,
    input  logic     wb_b_long_done,
    input  reg_idx_t wb_b_dest,
    output logic     issue_a,
    output logic     issue_b,
    output logic     id_stall,
    output logic     pending_any
);

    cnt_vec_t r_cnt;
    cnt_vec_t w_eff;
    cnt_vec_t w_next;

    logic w_a_src_ok;
    logic w_a_dest_ok;
    logic w_b_src_ok;
    logic w_b_dest_ok;
    logic w_b_extra;
    logic w_b_raw;
    logic w_b_pair_ok;

    always_comb begin
        w_eff = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            w_eff[r] = sat_dec(r_cnt[r],
                {1'b0, wb_a_long_done && (wb_a_dest == reg_idx_t'(r))} +
                {1'b0, wb_b_long_done && (wb_b_dest == reg_idx_t'(r))});
        end
    end

    issue_pair_check u_chk_a (
        .i_eff     (w_eff),
        .i_src1    (id_a_src1),
        .i_src2    (id_a_src2),
        .i_use1    (id_a_use_src1),
        .i_use2    (id_a_use_src2),
        .i_dest    (id_a_dest),
        .i_long    (id_a_long),
        .i_extra   (1'b0),
        .o_src_ok  (w_a_src_ok),
        .o_dest_ok (w_a_dest_ok)
    );

    assign w_b_extra = id_a_long && (id_a_dest == id_b_dest);

    issue_pair_check u_chk_b (
        .i_eff     (w_eff),
        .i_src1    (id_b_src1),
        .i_src2    (id_b_src2),
        .i_use1    (id_b_use_src1),
        .i_use2    (id_b_use_src2),
        .i_dest    (id_b_dest),
        .i_long    (id_b_long),
        .i_extra   (w_b_extra),
        .o_src_ok  (w_b_src_ok),
        .o_dest_ok (w_b_dest_ok)
    );

    assign w_b_raw = (id_a_dest != '0) &&
        ((id_b_use_src1 && (id_b_src1 == id_a_dest)) ||
         (id_b_use_src2 && (id_b_src2 == id_a_dest)));

    assign w_b_pair_ok = !w_b_raw &&
        !(id_a_is_mem && id_b_is_mem) &&
        !id_a_is_spec_op && !id_b_is_spec_op;

    assign issue_a = resetn && id_a_valid && !ro_stall && !flush &&
        w_a_src_ok && w_a_dest_ok;

    assign issue_b = issue_a && id_b_valid && w_b_src_ok &&
        w_b_dest_ok && w_b_pair_ok;

    assign id_stall = resetn && id_a_valid && !issue_a;

    assign pending_any = |r_cnt;

    // Issue checks above guarantee the sum never exceeds CNT_MAX.
    always_comb begin
        w_next = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            w_next[r] = w_eff[r] +
                {1'b0, issue_a && id_a_long && (id_a_dest == reg_idx_t'(r))} +
                {1'b0, issue_b && id_b_long && (id_b_dest == reg_idx_t'(r))};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

endmodule
